uart_tx_port: RTL

UART_TX_PORT -- requirements
Module: uart_tx_port

---
 rtl/uart_tx_port.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter: DATA/STATUS registers, a TX FIFO and a serialiser.
// Define UART_TX_FIFO_EN for a 4-entry FIFO; otherwise a single holding register is used.
module uart_tx_port #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter logic [15:0] BASE_ADDR    = 16'h8410
) (
    input  logic        cpu_clk,
    input  logic        reset_n,
    input  logic [15:0] addr,
    input  logic [7:0]  data_in,
    input  logic        write_enable,
    output logic [7:0]  data_out,
    output logic        tx,
    output logic        busy
);

`ifdef UART_TX_FIFO_EN
    localparam int unsigned DEPTH = 4;
`else
    localparam int unsigned DEPTH = 1;
`endif
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [15:0]       STATUS_ADDR = BASE_ADDR + 16'd1;
    localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t              r_state;
    logic [BAUD_W-1:0]   r_baud;
    logic [2:0]          r_bit_idx;
    logic [7:0]          r_shift;
    logic                r_tx;
    logic                r_busy;
    logic [CNT_W-1:0]    r_count;
    logic                r_ovf;
    logic [15:0]         r_addr;
    logic [7:0]          r_status;

    logic                w_full;
    logic                w_empty;
    logic                w_wr_hit;
    logic                w_push;
    logic                w_pop;
    logic                w_ovf_set;
    logic                w_bit_end;
    logic [7:0]          w_head;
    logic [7:0]          w_status;

    assign w_full    = (r_count == CNT_FULL);
    assign w_empty   = (r_count == '0);
    assign w_wr_hit  = write_enable && (addr == BASE_ADDR);
    assign w_push    = w_wr_hit && !w_full;
    assign w_ovf_set = w_wr_hit && w_full;
    assign w_bit_end = (r_baud == BAUD_LAST);
    assign w_status  = {4'b0000, r_ovf, r_busy, w_empty, w_full};

    // Head is consumed when idle, or at the last cycle of a stop bit for gapless frames.
    always_comb begin
        w_pop = 1'b0;
        if (!w_empty) begin
            if (r_state == ST_IDLE)
                w_pop = 1'b1;
            else if ((r_state == ST_STOP) && w_bit_end)
                w_pop = 1'b1;
        end
    end

    if (DEPTH > 1) begin : g_fifo
        localparam int unsigned PTR_W = $clog2(DEPTH);
        localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

        logic [7:0]       r_mem [DEPTH];
        logic [PTR_W-1:0] r_wr_ptr;
        logic [PTR_W-1:0] r_rd_ptr;

        always_ff @(posedge cpu_clk or negedge reset_n) begin
            if (!reset_n) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push)
                    r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
                if (w_pop)
                    r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
            end
        end

        always_ff @(posedge cpu_clk) begin
            if (w_push)
                r_mem[r_wr_ptr] <= data_in;
        end

        assign w_head = r_mem[r_rd_ptr];
    end else begin : g_hold
        logic [7:0] r_hold;

        always_ff @(posedge cpu_clk) begin
            if (w_push)
                r_hold <= data_in;
        end

        assign w_head = r_hold;
    end

    // Occupancy count and sticky overflow flag.
    always_ff @(posedge cpu_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_ovf_set)
                r_ovf <= 1'b1;
            else if (addr == STATUS_ADDR)
                r_ovf <= 1'b0;
        end
    end

    // Read port: the STATUS snapshot is taken at the same edge that clears overflow.
    always_ff @(posedge cpu_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr   <= '0;
            r_status <= '0;
        end else begin
            r_addr   <= addr;
            r_status <= w_status;
        end
    end

    assign data_out = (r_addr == STATUS_ADDR) ? r_status :
                      (r_addr == BASE_ADDR)   ? 8'h00    : 8'bzzzz_zzzz;

    // Serialiser FSM with registered line and busy outputs.
    always_ff @(posedge cpu_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    if (w_pop) begin
                        r_state <= ST_START;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_baud  <= '0;
                        r_shift <= w_head;
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_state   <= ST_DATA;
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= ST_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_shift[1];
                            r_shift   <= r_shift >> 1;
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                ST_STOP: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_state <= ST_START;
                            r_tx    <= 1'b0;
                            r_shift <= w_head;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx   = r_tx;
    assign busy = r_busy;

endmodule
